// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode seven-segment scan driver.
// Data is snapshotted once per frame and decoded into a registered, active-low output stage.
module seg7_scan_driver #(
  parameter int unsigned SCAN_CNT   = 50000,
  parameter int unsigned BLINK_BITS = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  LE,
  input  logic [7:0]  point,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_tick
);

  localparam int unsigned CntW = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [BLINK_BITS-1:0] blink_q;
  logic [31:0]           snap_num_q;
  logic [7:0]            snap_le_q, snap_pt_q;
  logic                  frame_start;
  logic [3:0]            nib;
  logic [7:0]            an_d, seg_d;

  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign frame_start = (cnt_q == '0) && (idx_q == 3'd0);

  // Digit dwell divider; the 3-bit index wraps 7 -> 0 naturally.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntW'(SCAN_CNT - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      blink_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      blink_q <= blink_q + BLINK_BITS'(1);
    end
  end

  // Frame-coherent snapshot: only the first cycle of a frame may load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_num_q <= 32'h0;
      snap_le_q  <= 8'h0;
      snap_pt_q  <= 8'h0;
    end else if (frame_start && EN) begin
      snap_num_q <= Disp_num;
      snap_le_q  <= LE;
      snap_pt_q  <= point;
    end
  end

  always_comb begin
    nib   = snap_num_q[{idx_q, 2'b00} +: 4];
    an_d  = ~(8'h01 << idx_q);
    seg_d = {~snap_pt_q[idx_q], hex2seg(nib)};
    // Blanking leaves AN walking so per-digit timing never changes.
    if (snap_le_q[idx_q] && blink_q[BLINK_BITS-1]) begin
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AN         <= 8'hFF;
      SEGMENT    <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      AN         <= an_d;
      SEGMENT    <= seg_d;
      frame_tick <= frame_start;
    end
  end

endmodule
